// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: turns the read port of a non-FWFT synchronous FIFO into a
// valid/ready stream through a 3-entry circular buffer.
module fifo_stream_rd #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_count
);

  localparam int DEPTH = 3;

  logic [1:0]       head_reg, head_next;
  logic [1:0]       tail_reg, tail_next;
  logic [1:0]       count_reg, count_next;
  logic             inflight_reg, inflight_next;
  logic             capture;
  logic             transfer;
  logic [2:0]       occupancy;
  logic [WIDTH-1:0] entry_word [DEPTH];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are throttled on buffered plus in-flight words, so a slot is
  // always reserved for the word returning next cycle.
  assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign fifo_rd_en = rstn & ~flush & ~fifo_empty & (occupancy < 3'd3);

  assign capture  = inflight_reg;
  assign transfer = m_valid & m_ready;

  // Outputs are forced idle while reset is held, before the clearing edge.
  assign m_valid = rstn & (count_reg != 2'd0);
  assign m_count = rstn ? count_reg : 2'd0;

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    inflight_next = fifo_rd_en;
    if (capture) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (transfer) begin
      head_next = ptr_inc(head_reg);
    end
    case ({capture, transfer})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    if (!rstn || flush) begin
      head_next     = 2'd0;
      tail_next     = 2'd0;
      count_next    = 2'd0;
      inflight_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    head_reg     <= head_next;
    tail_reg     <= tail_next;
    count_reg    <= count_next;
    inflight_reg <= inflight_next;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (rstn && !flush && capture && (tail_reg == 2'(gi))) begin
          word_reg <= fifo_dout;
        end
      end

      assign entry_word[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    case (head_reg)
      2'd1:    m_data = entry_word[1];
      2'd2:    m_data = entry_word[2];
      default: m_data = entry_word[0];
    endcase
  end

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: behavioural upstream FIFO, queue-based scoreboard
// of words read but not yet delivered, directed scenarios plus a random soak.
module tb_fifo_stream_rd;

  localparam int W = 36;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_count;

  always #5 clk = ~clk;

  fifo_stream_rd #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_count    (m_count)
  );

  logic [W-1:0] fifo_q [$];  // upstream FIFO contents
  logic [W-1:0] exp_q  [$];  // words read from the FIFO, not yet delivered
  bit           infl_m = 1'b0;
  bit           dout_load = 1'b0;
  logic [W-1:0] dout_next = '0;
  int           tests = 0;
  int           failed = 0;
  int           cyc = 0;
  int           rd_cnt = 0;
  int           xfer_cnt = 0;
  int           first_rd = -1;
  int           first_valid = -1;
  int           run_len = 0;
  int           max_run = 0;
  int           exp_cnt;
  logic         exp_rd;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      if (failed <= 30)
        $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: samples on the falling edge what the next rising edge will do.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      exp_cnt = exp_q.size() - int'(infl_m);
      if (!rstn) begin
        check("rst_m_valid", W'(m_valid), '0);
        check("rst_m_count", W'(m_count), '0);
        check("rst_rd_en", W'(fifo_rd_en), '0);
      end else begin
        check("m_count", W'(m_count), W'(exp_cnt));
        check("m_valid", W'(m_valid), W'(exp_cnt != 0));
        if (exp_cnt != 0) check("m_data", m_data, exp_q[0]);
        exp_rd = !flush && !fifo_empty && (exp_q.size() < 3);
        check("fifo_rd_en", W'(fifo_rd_en), W'(exp_rd));
      end
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_valid && first_valid < 0) first_valid = cyc;
      run_len = m_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      dout_load = 1'b0;
      if (!rstn || flush) begin
        exp_q.delete();
        infl_m = 1'b0;
      end else begin
        if (m_valid && m_ready && exp_cnt > 0) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
        infl_m = fifo_rd_en;
        if (fifo_rd_en && fifo_q.size() > 0) begin
          dout_next = fifo_q.pop_front();
          exp_q.push_back(dout_next);
          dout_load = 1'b1;
          rd_cnt++;
        end
      end
    end
  end

  // Upstream FIFO read data: valid one cycle after the read, garbage otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fifo_dout = dout_load ? dout_next : W'({$urandom(), $urandom()});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, W'(n < 2000), W'(1'b1));
  endtask

  initial begin
    int x0;
    int r0;
    int n;
    int pushed;
    int gate;

    // Reset with FIFO preloaded, then streaming with m_ready high
    for (int i = 0; i < 8; i++) fifo_q.push_back(W'(36'h101 + i));
    rstn = 1'b0;
    repeat (3) tick();
    first_rd = -1;
    first_valid = -1;
    max_run = 0;
    x0 = xfer_cnt;
    m_ready = 1'b1;
    rstn = 1'b1;
    repeat (14) tick();
    check("a_latency", W'(first_valid - first_rd), W'(2));
    check("a_run", W'(max_run), W'(8));
    check("a_xfers", W'(xfer_cnt - x0), W'(8));
    $display("[TB] phase A: preload 0x101..0x108, latency %0d, run %0d", first_valid - first_rd, max_run);

    // Stalled consumer: buffer fills to 3 and reads stop
    m_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) fifo_q.push_back(W'(36'h200 + i));
    repeat (10) tick();
    check("b_reads", W'(rd_cnt - r0), W'(3));
    check("b_m_count", W'(m_count), W'(3));
    check("b_rd_en", W'(fifo_rd_en), '0);
    check("b_m_valid", W'(m_valid), W'(1));
    check("b_m_data", m_data, W'(36'h200));
    m_ready = 1'b1;
    wait_drain("b");
    $display("[TB] phase B: stalled fill, reads %0d", rd_cnt - r0);

    // Flush with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(W'(36'h300 + i));
    n = 0;
    while (m_count != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    check("c_fill_timeout", W'(n < 20), W'(1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("c_m_valid", W'(m_valid), '0);
    check("c_m_count", W'(m_count), '0);
    m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check("c_next_word", m_data, W'(36'h303));
    wait_drain("c");
    $display("[TB] phase C: flush with in-flight word, next word %h", W'(36'h303));

    // One-cycle reset in the middle of a stream
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) fifo_q.push_back(W'(36'h400 + i));
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check("d_rst_m_valid", W'(m_valid), '0);
    check("d_rst_rd_en", W'(fifo_rd_en), '0);
    tick();
    rstn = 1'b1;
    wait_drain("d");
    $display("[TB] phase D: mid-stream reset, stream resumed");

    // Random soak: random ready, bursty fill, rare flush
    x0 = xfer_cnt;
    pushed = 0;
    gate = 50;
    for (int c = 0; c < 60000 && (pushed < 10000 || fifo_q.size() != 0 || exp_q.size() != 0); c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       gate = 5;
          1:       gate = 50;
          default: gate = 95;
        endcase
      end
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 10000 && fifo_q.size() < 12 && int'($urandom_range(0, 99)) < gate) begin
        fifo_q.push_back(W'({$urandom(), $urandom()}));
        pushed++;
      end
      flush = ($urandom_range(0, 999) == 0);
      tick();
    end
    flush = 1'b0;
    check("e_pushed", W'(pushed), W'(10000));
    check("e_delivered", W'((xfer_cnt - x0) >= 9800), W'(1'b1));
    check("e_drained", W'(exp_q.size() + fifo_q.size()), '0);
    $display("[TB] phase E: random soak, %0d pushed, %0d delivered", pushed, xfer_cnt - x0);

    // Full 36-bit words across several pointer wraps
    x0 = xfer_cnt;
    for (int i = 0; i < 12; i++) fifo_q.push_back(W'(36'hF_0000_0001 + i));
    for (int c = 0; c < 400 && (fifo_q.size() != 0 || exp_q.size() != 0); c++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("f_xfers", W'(xfer_cnt - x0), W'(12));
    $display("[TB] phase F: 36-bit pattern, %0d delivered", xfer_cnt - x0);

    m_ready = 1'b0;
    repeat (3) tick();
    check("end_m_count", W'(m_count), '0);
    check("end_scoreboard", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
